vga_timing_gen: RTL

Parametrised VGA timing generator and pixel output stage, the successor to the fixed-mode 640x480 controller. It derives a pixel-rate tick from the system clock and runs horizontal and vertical counters with fully configurable porch, sync and active lengths. It requests pixel data one pixel ahead via `x`, `y` and `pix_req`, and drives registered `HS`, `VS` and colour outputs, blanked outside the active area. It sits between the frame/pixel source and the board VGA pins.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA timing generator.
//   - 640x480@60 default horizontal/vertical timing (pixels / lines)
//   - sync polarity encodings for the SYNC_POL parameter
//   - clog2 / clog2w width helpers usable in parameter expressions
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  // Bit width able to hold 0..value-1, never narrower than one bit.
  function automatic int unsigned clog2w(input int unsigned value);
    return (clog2(value) > 0) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
// Counts 0..TOTAL-1 while en is high and decodes the region flags.
// Ports:
//   clk, reset (sync, active-high), en   - clock, reset, count enable
//   cnt    - current position on the axis
//   wrap   - cnt is at TOTAL-1 (next enabled step returns to 0)
//   active - cnt is inside the visible region
//   sync   - cnt is inside the sync pulse (active-high, polarity applied by the top)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int unsigned CW    = clog2w(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  logic [CW-1:0] r_cnt;
  logic [31:0]   w_cnt32;

  // Decode in 32 bits so ACTIVE+FP+SYNC may equal 2**CW without truncation.
  assign w_cnt32 = 32'(r_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = (w_cnt32 == TOTAL - 1);
  assign active = (w_cnt32 < ACTIVE);
  assign sync   = (w_cnt32 >= ACTIVE + FP) && (w_cnt32 < ACTIVE + FP + SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and pixel output stage.
// A pixel tick is derived from clk; a request stage presents (x, y, pix_req)
// one pixel ahead, and an output stage drives HS/VS and blanked colour.
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   pix_in           - {red, green, blue} for the pixel requested on the previous tick
//   x, y, pix_req    - requested pixel position and its validity
//   frame_start      - one-clk pulse when the request stage loads (0,0)
//   HS, VS           - sync outputs, active level SYNC_POL
//   red, green, blue - colour outputs, zero outside the active area
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned R_W      = 3,
  parameter int unsigned G_W      = 3,
  parameter int unsigned B_W      = 2,
  localparam int unsigned XW = clog2w(H_ACTIVE),
  localparam int unsigned YW = clog2w(V_ACTIVE),
  localparam int unsigned PW = R_W + G_W + B_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] pix_in,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          pix_req,
  output logic          frame_start,
  output logic          HS,
  output logic          VS,
  output logic [R_W-1:0] red,
  output logic [G_W-1:0] green,
  output logic [B_W-1:0] blue
);

  localparam int unsigned HW = clog2w(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW = clog2w(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned DW = clog2w(CLK_DIV);

  // Pixel tick divider
  logic [DW-1:0] r_div;
  logic          w_tick;

  assign w_tick = (32'(r_div) == CLK_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // Axis counters
  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_h_wrap, w_h_active, w_h_sync;
  logic          w_unused_v_wrap;
  logic          w_v_active, w_v_sync;
  logic          w_active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (w_tick),
    .cnt    (w_h_cnt),
    .wrap   (w_h_wrap),
    .active (w_h_active),
    .sync   (w_h_sync)
  );

  // Frame end is implied by the vertical counter returning to 0 with h; the
  // explicit wrap flag is not needed here.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (w_tick && w_h_wrap),
    .cnt    (w_v_cnt),
    .wrap   (w_unused_v_wrap),
    .active (w_v_active),
    .sync   (w_v_sync)
  );

  assign w_active = w_h_active && w_v_active;

  // Request stage
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_pix_req;
  logic          r_hsync_req;
  logic          r_vsync_req;
  logic          r_frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_pix_req     <= 1'b0;
      r_hsync_req   <= 1'b0;
      r_vsync_req   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // Only high on a tick, so it drops on the next clk whatever CLK_DIV is.
      r_frame_start <= w_tick && (w_h_cnt == '0) && (w_v_cnt == '0);
      if (w_tick) begin
        r_pix_req   <= w_active;
        r_x         <= w_active ? w_h_cnt[XW-1:0] : '0;
        r_y         <= w_active ? w_v_cnt[YW-1:0] : '0;
        r_hsync_req <= w_h_sync;
        r_vsync_req <= w_v_sync;
      end
    end
  end

  // Output stage: one pixel behind the request stage. pix_in on this tick
  // belongs to the pixel requested last tick, so r_pix_req gates it.
  logic           r_hs, r_vs;
  logic [R_W-1:0] r_red;
  logic [G_W-1:0] r_green;
  logic [B_W-1:0] r_blue;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (w_tick) begin
      r_hs    <= r_hsync_req ? SYNC_POL : ~SYNC_POL;
      r_vs    <= r_vsync_req ? SYNC_POL : ~SYNC_POL;
      r_red   <= r_pix_req ? pix_in[PW-1 -: R_W]        : '0;
      r_green <= r_pix_req ? pix_in[G_W+B_W-1 -: G_W]   : '0;
      r_blue  <= r_pix_req ? pix_in[B_W-1:0]            : '0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign pix_req     = r_pix_req;
  assign frame_start = r_frame_start;
  assign HS          = r_hs;
  assign VS          = r_vs;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;

endmodule
